uart_puf_bridge: RTL



---
 rtl/uart_puf_bridge.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_puf_bridge.sv
// Byte-level host protocol between the UART wrapper and the PUF core:
// collects a framed challenge, runs one PUF evaluation, returns the framed response.
module uart_puf_bridge #(
    parameter int          DATA_BITS       = 8,
    parameter int          CHALLENGE_BYTES = 4,
    parameter int          RESPONSE_BYTES  = 2,
    parameter int          RX_TIMEOUT      = 1_000_000,
    parameter logic [7:0]  CMD_HDR         = 8'hA5,
    parameter logic [7:0]  RSP_HDR         = 8'h5A
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic [DATA_BITS-1:0]          rx_data,
    input  logic                          rx_valid,
    output logic                          rx_enable,
    output logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_enable,
    input  logic                          tx_busy,
    output logic [8*CHALLENGE_BYTES-1:0]  challenge,
    output logic                          puf_start,
    input  logic                          puf_done,
    input  logic [8*RESPONSE_BYTES-1:0]   response,
    output logic                          busy,
    output logic                          timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_CHAL,
        S_PUF_REQ,
        S_PUF_WAIT,
        S_TX_BYTE,
        S_TX_GUARD,
        S_TX_WAIT
    } state_e;

    localparam int                 TIMER_W    = $clog2(RX_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RX_TIMEOUT - 1);
    localparam logic [4:0]         CHAL_LAST  = 5'(CHALLENGE_BYTES - 1);
    localparam logic [4:0]         RESP_CNT   = 5'(RESPONSE_BYTES);

    state_e                         state_q, state_d;
    logic [4:0]                     rx_cnt_q;
    logic [4:0]                     tx_cnt_q;
    logic [TIMER_W-1:0]             timer_q;
    logic [8*RESPONSE_BYTES-1:0]    shift_q;
    logic [8*CHALLENGE_BYTES-1:0]   challenge_q;
    logic [DATA_BITS-1:0]           tx_data_q;
    logic                           tx_enable_q;
    logic                           puf_start_q;
    logic                           timeout_err_q;
    logic                           busy_q;
    logic                           rx_enable_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (rx_valid && rx_data == CMD_HDR) state_d = S_RX_CHAL;
            S_RX_CHAL: begin
                // An arriving byte always beats an expiring timer.
                if (rx_valid) begin
                    if (rx_cnt_q == CHAL_LAST) state_d = S_PUF_REQ;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_PUF_REQ:  state_d = S_PUF_WAIT;
            S_PUF_WAIT: if (puf_done) state_d = S_TX_BYTE;
            S_TX_BYTE:  if (!tx_busy) state_d = S_TX_GUARD;
            S_TX_GUARD: state_d = S_TX_WAIT;
            S_TX_WAIT:  if (!tx_busy) state_d = (tx_cnt_q == RESP_CNT) ? S_IDLE : S_TX_BYTE;
            default:    state_d = S_IDLE;
        endcase
    end

    // NOTE: every register here is state, so all updates are non-blocking.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= S_IDLE;
            rx_cnt_q      <= '0;
            tx_cnt_q      <= '0;
            timer_q       <= '0;
            shift_q       <= '0;
            challenge_q   <= '0;
            tx_data_q     <= '0;
            tx_enable_q   <= 1'b0;
            puf_start_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            rx_enable_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            busy_q        <= (state_d != S_IDLE);
            rx_enable_q   <= (state_d == S_IDLE) || (state_d == S_RX_CHAL);
            puf_start_q   <= (state_d == S_PUF_REQ);
            tx_enable_q   <= (state_d == S_TX_GUARD);
            timeout_err_q <= (state_q == S_RX_CHAL) && (state_d == S_IDLE);

            case (state_q)
                S_IDLE: begin
                    if (state_d == S_RX_CHAL) begin
                        rx_cnt_q <= '0;
                        timer_q  <= '0;
                    end
                end
                S_RX_CHAL: begin
                    if (rx_valid) begin
                        challenge_q[{rx_cnt_q, 3'b000} +: 8] <= rx_data;
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                        timer_q  <= '0;
                    end else begin
                        timer_q  <= timer_q + 1'b1;
                    end
                end
                S_PUF_WAIT: begin
                    if (puf_done) begin
                        shift_q   <= response;
                        tx_data_q <= RSP_HDR;
                        tx_cnt_q  <= '0;
                    end
                end
                S_TX_WAIT: begin
                    // Payload leaves least-significant byte first.
                    if (!tx_busy && tx_cnt_q != RESP_CNT) begin
                        tx_data_q <= shift_q[7:0];
                        shift_q   <= shift_q >> 8;
                        tx_cnt_q  <= tx_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_enable   = rx_enable_q;
    assign tx_data     = tx_data_q;
    assign tx_enable   = tx_enable_q;
    assign challenge   = challenge_q;
    assign puf_start   = puf_start_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
